// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART 8N1 receiver, 16x oversampled, feeding an 8-deep read FIFO
module uart_rx_fifo #(
    parameter int CLKS_PER_TICK = 651,
    parameter int DATA_BITS     = 8,
    parameter int FIFO_DEPTH    = 8,
    parameter int PTR_W         = 3
) (
    input  logic                 i_pclk,
    input  logic                 i_rst_n,
    input  logic                 i_rx,
    input  logic                 i_rd_req,
    input  logic                 i_err_clr,
    output logic [DATA_BITS-1:0] o_rd_data,
    output logic                 o_rd_ready,
    output logic                 o_fifo_empty,
    output logic                 o_fifo_full,
    output logic [PTR_W:0]       o_fifo_count,
    output logic                 o_frame_err,
    output logic                 o_overrun_err
);
    localparam int TICK_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_TICK - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
    localparam logic [PTR_W:0]    CNT_FULL  = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]    CNT_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic                 r_rx_meta;
    logic                 r_rx_sync;
    logic [1:0]           r_state;
    logic [TICK_W-1:0]    r_tick_cnt;
    logic [3:0]           r_s;
    logic [BIT_W-1:0]     r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_push;
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [PTR_W:0]       r_count;
    logic [DATA_BITS-1:0] r_rd_data;
    logic                 r_rd_ready;
    logic                 r_frame_err;
    logic                 r_overrun_err;

    logic w_tick;
    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push_ok;
    logic w_overrun;
    logic w_stop_bad;

    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // Counter parked at zero in IDLE so every bit is timed from the detected falling edge
    assign w_tick = (r_state != S_IDLE) && (r_tick_cnt == TICK_LAST);

    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tick_cnt <= '0;
        end else if (r_state == S_IDLE || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TICK_ONE;
        end
    end

    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_s       <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_push    <= 1'b0;
        end else begin
            r_push <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_s <= '0;
                    if (!r_rx_sync) r_state <= S_START;
                end
                S_START: if (w_tick) begin
                    if (r_s == 4'd7) begin
                        r_s       <= '0;
                        r_bit_idx <= '0;
                        r_state   <= r_rx_sync ? S_IDLE : S_DATA;
                    end else begin
                        r_s <= r_s + 4'd1;
                    end
                end
                S_DATA: if (w_tick) begin
                    if (r_s == 4'd15) begin
                        r_s                 <= '0;
                        r_shift[r_bit_idx]  <= r_rx_sync;
                        if (r_bit_idx == BIT_LAST) r_state <= S_STOP;
                        else r_bit_idx <= r_bit_idx + BIT_ONE;
                    end else begin
                        r_s <= r_s + 4'd1;
                    end
                end
                default: if (w_tick) begin
                    if (r_s == 4'd15) begin
                        r_push  <= r_rx_sync;
                        r_state <= S_IDLE;
                    end else begin
                        r_s <= r_s + 4'd1;
                    end
                end
            endcase
        end
    end

    assign w_stop_bad = (r_state == S_STOP) && w_tick && (r_s == 4'd15) && !r_rx_sync;
    assign w_full     = (r_count == CNT_FULL);
    assign w_empty    = (r_count == '0);
    // Skip the cycle rd_ready is high: the slave is still holding rd_req while it sees completion
    assign w_pop      = i_rd_req && !w_empty && !r_rd_ready;
    assign w_push_ok  = r_push && (!w_full || w_pop);
    assign w_overrun  = r_push && w_full && !w_pop;

    always_ff @(posedge i_pclk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= r_shift;
    end

    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_rd_data     <= '0;
            r_rd_ready    <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_rd_ready <= w_pop;
            if (w_pop) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + PTR_ONE;
            end
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_stop_bad) r_frame_err <= 1'b1;
            else if (i_err_clr) r_frame_err <= 1'b0;
            if (w_overrun) r_overrun_err <= 1'b1;
            else if (i_err_clr) r_overrun_err <= 1'b0;
        end
    end

    assign o_rd_data     = r_rd_data;
    assign o_rd_ready    = r_rd_ready;
    assign o_fifo_empty  = w_empty;
    assign o_fifo_full   = w_full;
    assign o_fifo_count  = r_count;
    assign o_frame_err   = r_frame_err;
    assign o_overrun_err = r_overrun_err;
endmodule
